// File: rtl/isp_awb_stats_pkg.sv
// isp_awb_stats_pkg: shared constants and FSM encoding for the AWB statistics engine
package isp_awb_stats_pkg;
    localparam int AWB_GAIN_ONE = 256;
    localparam int AWB_GAIN_MAX = 1023;
    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, DONE} awb_state_t;
endpackage

// File: rtl/isp_seq_divider.sv
// isp_seq_divider: restoring divider, one quotient bit per cycle, W cycles from start
module isp_seq_divider #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] numer,
    input  logic [W-1:0] denom,
    output logic         done,
    output logic [W-1:0] quot
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0] num_q, den_q, rem_q, num_s, den_s, rem_s;
    logic [W:0] trial;
    logic [CW-1:0] cnt_q;
    logic done_q, fits, step;
    // start performs the first step directly on the fresh operands
    always_comb begin
        num_s = start ? numer : num_q;
        den_s = start ? denom : den_q;
        rem_s = start ? '0 : rem_q;
        trial = {rem_s, num_s[W-1]};
        fits  = trial >= {1'b0, den_s};
        step  = start || cnt_q != '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= !start && cnt_q == CW'(1);
            if (step) begin
                num_q <= {num_s[W-2:0], fits};
                den_q <= den_s;
                rem_q <= fits ? W'(trial - {1'b0, den_s}) : trial[W-1:0];
                cnt_q <= start ? CW'(W - 1) : cnt_q - CW'(1);
            end
        end
    end
    assign done = done_q;
    assign quot = num_q;
endmodule

// File: rtl/isp_awb_stats.sv
// isp_awb_stats: per-frame RGB sums and green-normalised AWB gains for the next frame
module isp_awb_stats
    import isp_awb_stats_pkg::*;
#(
    parameter int RGB_WIDTH = 24,
    parameter int SUM_W     = 32,
    parameter int GAIN_W    = 10,
    parameter int MIN_PIX   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RGB_WIDTH-1:0] rgb_in,
    input  logic                 rgb_valid,
    input  logic                 csi_in_frame,
    output logic [GAIN_W-1:0]    gain_r,
    output logic [GAIN_W-1:0]    gain_g,
    output logic [GAIN_W-1:0]    gain_b,
    output logic                 gains_valid,
    output logic                 busy,
    output logic                 stats_dropped,
    output logic [SUM_W-1:0]     pix_count
);
    localparam int DW = SUM_W + 8;
    awb_state_t state_q, state_d;
    logic csi_q, gv_q, drop_q, rise, fall, take, qual, accept;
    logic [3:0][7:0] px;
    logic [3:0][SUM_W-1:0] acc_q, acc_d;
    logic [2:0][SUM_W-1:0] snap_q;
    logic [1:0][GAIN_W-1:0] pend_q, gain_q;
    logic [SUM_W-1:0] pix_q;
    logic div_start, div_done, div_zero;
    logic [DW-1:0] div_num, div_den, div_quot;
    logic [GAIN_W-1:0] div_gain;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [7:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {{(SUM_W - 7){1'b0}}, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    // acc[3..1] = R, G, B sums; acc[0] = pixel count (adds a constant 1)
    assign px     = {rgb_in, 8'd1};
    assign rise   = csi_in_frame && !csi_q;
    assign fall   = !csi_in_frame && csi_q;
    assign take   = csi_in_frame && rgb_valid;
    assign qual   = acc_q[0] >= SUM_W'(MIN_PIX);
    assign accept = fall && qual && state_q == IDLE;

    always_comb begin
        for (int i = 0; i < 4; i++) acc_d[i] = take ? sat_add(rise ? '0 : acc_q[i], px[i]) : (rise ? '0 : acc_q[i]);
    end

    // red division starts straight from the accumulators in the accepting cycle
    assign div_start = accept || (state_q == DIV_R && div_done);
    assign div_num   = {state_q == IDLE ? acc_q[2] : snap_q[1], 8'd0};
    assign div_den   = {8'd0, state_q == IDLE ? acc_q[3] : snap_q[0]};
    assign div_zero  = state_q == DIV_R ? snap_q[2] == '0 : snap_q[0] == '0;
    assign div_gain  = div_zero ? GAIN_W'(AWB_GAIN_ONE) : (|div_quot[DW-1:GAIN_W] ? '1 : div_quot[GAIN_W-1:0]);

    isp_seq_divider #(.W(DW)) u_div (
        .clk(clk), .rst(rst), .start(div_start), .numer(div_num), .denom(div_den),
        .done(div_done), .quot(div_quot)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? DIV_R : IDLE;
            DIV_R:   state_d = div_done ? DIV_B : DIV_R;
            DIV_B:   state_d = div_done ? DONE : DIV_B;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            csi_q   <= 1'b0;
            acc_q   <= '0;
            snap_q  <= '0;
            pix_q   <= '0;
            pend_q  <= {2{GAIN_W'(AWB_GAIN_ONE)}};
            gain_q  <= {2{GAIN_W'(AWB_GAIN_ONE)}};
            gv_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            csi_q   <= csi_in_frame;
            acc_q   <= acc_d;
            gv_q    <= state_q == DONE;
            drop_q  <= fall && qual && state_q != IDLE;
            if (fall) pix_q <= acc_q[0];
            if (accept) snap_q <= acc_q[3:1];
            if (state_q == DIV_R && div_done) pend_q[1] <= div_gain;
            if (state_q == DIV_B && div_done) pend_q[0] <= div_gain;
            if (state_q == DONE) gain_q <= pend_q;
        end
    end

    assign gain_r        = gain_q[1];
    assign gain_b        = gain_q[0];
    assign gain_g        = GAIN_W'(AWB_GAIN_ONE);
    assign gains_valid   = gv_q;
    assign busy          = state_q != IDLE;
    assign stats_dropped = drop_q;
    assign pix_count     = pix_q;
endmodule

// File: tb/tb_isp_awb_stats.sv
// tb_isp_awb_stats: frame-level AWB model checked every cycle, plus directed literal checks
module tb_isp_awb_stats;
    localparam int MINP = 1024;
    logic clk = 1'b0, rst = 1'b1;
    logic [23:0] rgb_in = '0, rgb2 = '0;
    logic rgb_valid = 1'b0, csi = 1'b0, v2 = 1'b0, csi2 = 1'b0;
    logic [9:0] gain_r, gain_g, gain_b, gr2, gg2, gb2;
    logic gains_valid, busy, stats_dropped, gv2, busy2, drop2;
    logic [31:0] pix_count, pc2;
    int errs = 0, checks = 0, cyc = 0, drops2 = 0, gvs2 = 0, k = 0;

    isp_awb_stats #(.MIN_PIX(MINP)) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .csi_in_frame(csi),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b), .gains_valid(gains_valid),
        .busy(busy), .stats_dropped(stats_dropped), .pix_count(pix_count)
    );
    isp_awb_stats #(.MIN_PIX(16)) dut2 (
        .clk(clk), .rst(rst), .rgb_in(rgb2), .rgb_valid(v2), .csi_in_frame(csi2),
        .gain_r(gr2), .gain_g(gg2), .gain_b(gb2), .gains_valid(gv2),
        .busy(busy2), .stats_dropped(drop2), .pix_count(pc2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // frame-level model: sums per frame, gains appear 82 cycles after frame end
    longint m_sum[3], m_cnt;
    logic m_prev = 1'b0, m_pend = 1'b0, m_gv = 1'b0, m_drop = 1'b0;
    int m_gr = 256, m_gb = 256, p_gr = 256, p_gb = 256, m_edge = 0, m_done_at = 0;
    logic [31:0] m_pix = '0;

    function automatic int gain_of(input longint g, input longint d);
        longint q;
        if (d == 0) return 256;
        q = (g * 256) / d;
        return q > 1023 ? 1023 : int'(q);
    endfunction

    task automatic model_step();
        logic fall, rise;
        longint v;
        if (rst) begin
            m_sum = '{0, 0, 0}; m_cnt = 0; m_prev = 0; m_pend = 0; m_gv = 0; m_drop = 0;
            m_gr = 256; m_gb = 256; m_pix = '0;
            return;
        end
        m_edge++;
        fall = m_prev && !csi;
        rise = csi && !m_prev;
        m_gv = 0;
        m_drop = 0;
        if (fall) begin
            m_pix = 32'(m_cnt);
            if (m_cnt >= MINP) begin
                if (m_pend) m_drop = 1;
                else begin
                    p_gr = gain_of(m_sum[1], m_sum[0]);
                    p_gb = gain_of(m_sum[1], m_sum[2]);
                    m_pend = 1;
                    m_done_at = m_edge + 81;
                end
            end
        end
        if (m_pend && m_edge == m_done_at) begin
            m_gr = p_gr; m_gb = p_gb; m_gv = 1; m_pend = 0;
        end
        if (rise) begin
            m_sum = '{0, 0, 0}; m_cnt = 0;
        end
        if (csi && rgb_valid) begin
            for (int c = 0; c < 3; c++) begin
                v = m_sum[c] + longint'(rgb_in[23-8*c -: 8]);
                m_sum[c] = v > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : v;
            end
            m_cnt = m_cnt + 1 > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_cnt + 1;
        end
        m_prev = csi;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("gain_r", 32'(gain_r), m_gr);
        chk("gain_g", 32'(gain_g), 256);
        chk("gain_b", 32'(gain_b), m_gb);
        chk("gains_valid", 32'(gains_valid), 32'(m_gv));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("stats_dropped", 32'(stats_dropped), 32'(m_drop));
        chk("pix_count", pix_count, m_pix);
        drops2 += int'(drop2);
        gvs2 += int'(gv2);
    end

    task automatic drive(input bit which, input logic c, input logic v, input logic [23:0] p);
        @(posedge clk);
        #1;
        if (which) begin csi2 = c; v2 = v; rgb2 = p; end
        else begin csi = c; rgb_valid = v; rgb_in = p; end
    endtask

    task automatic frame(input bit which, input int lines, input int per_line,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, output int kend);
        drive(which, 1, 0, '0);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < per_line; p++) drive(which, 1, 1, {r, g, b});
            for (int p = 0; p < 8; p++) drive(which, 1, 0, '0);
        end
        drive(which, 0, 0, '0);
        kend = cyc;
    endtask

    task automatic wait_gv(input int kend, input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gains_valid) break;
        end
        chk(name, cyc - kend, 82);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_gain_r", 32'(gain_r), 256);
        chk("rst_gain_b", 32'(gain_b), 256);
        chk("rst_gain_g", 32'(gain_g), 256);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pix", pix_count, 0);
        chk("rst_gv", 32'(gains_valid), 0);

        frame(0, 2, 640, 64, 128, 128, k);
        wait_gv(k, "latency_640x2");
        chk("f1_gain_r", 32'(gain_r), 512);
        chk("f1_gain_b", 32'(gain_b), 256);
        chk("f1_pix", pix_count, 1280);

        frame(0, 1, 2048, 16, 200, 200, k);
        wait_gv(k, "latency_clamp");
        chk("clamp_gain_r", 32'(gain_r), 1023);
        chk("clamp_gain_b", 32'(gain_b), 256);

        frame(0, 1, 2048, 0, 100, 50, k);
        wait_gv(k, "latency_zero");
        chk("zero_gain_r", 32'(gain_r), 256);
        chk("zero_gain_b", 32'(gain_b), 512);

        frame(0, 1, 500, 10, 20, 30, k);
        for (int i = 0; i < 20; i++) drive(0, 0, i[0], 24'hFFFFFF);
        repeat (150) @(negedge clk);
        chk("short_pix", pix_count, 500);
        chk("short_gain_r", 32'(gain_r), 256);
        chk("short_gain_b", 32'(gain_b), 512);
        frame(0, 1, 1024, 32, 64, 128, k);
        wait_gv(k, "latency_min");
        chk("min_pix", pix_count, 1024);
        chk("min_gain_r", 32'(gain_r), 512);
        chk("min_gain_b", 32'(gain_b), 128);

        frame(0, 1, 1024, 64, 64, 64, k);
        repeat (55) @(posedge clk);
        #1 chk("divb_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pix", pix_count, 0);
        chk("abort_gain_r", 32'(gain_r), 256);
        chk("abort_gain_b", 32'(gain_b), 256);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(negedge clk);
        frame(0, 1, 1024, 50, 100, 200, k);
        wait_gv(k, "latency_after_abort");
        chk("post_gain_r", 32'(gain_r), 512);
        chk("post_gain_b", 32'(gain_b), 128);

        drops2 = 0;
        gvs2 = 0;
        frame(1, 1, 24, 64, 128, 128, k);
        frame(1, 1, 20, 128, 128, 64, k);
        repeat (150) @(negedge clk);
        chk("drop_pulses", drops2, 1);
        chk("drop_gv_pulses", gvs2, 1);
        chk("drop_gain_r", 32'(gr2), 512);
        chk("drop_gain_b", 32'(gb2), 256);
        chk("drop_gain_g", 32'(gg2), 256);
        chk("drop_pix", pc2, 20);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/isp_awb_stats.md
# isp_awb_stats

Auto-white-balance statistics and gain engine that sits directly downstream of the debayer/colour-balance ISP path. It watches the 24-bit RGB pixel stream, sums each channel over every valid pixel of a frame, and at frame end derives per-channel gains for the next frame with a sequential divider. Gains are normalised to green (green gain fixed at 1.0) and held stable for the whole following frame.

## Interface
Parameters:
- RGB_WIDTH, 24: pixel width, packed {R[23:16], G[15:8], B[7:0]}.
- SUM_W, 32: width of each channel accumulator.
- GAIN_W, 10: gain width, unsigned U2.8 (256 = 1.0).
- MIN_PIX, 1024: minimum valid pixels per frame for gains to update.

Ports:
- clk  in  1  byte clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- rgb_in  in  RGB_WIDTH  RGB pixel.
- rgb_valid  in  1  rgb_in is valid this cycle.
- csi_in_frame  in  1  high while a frame is in progress.
- gain_r  out  GAIN_W  red gain, U2.8.
- gain_g  out  GAIN_W  green gain, constant 256.
- gain_b  out  GAIN_W  blue gain, U2.8.
- gains_valid  out  1  one-cycle pulse when gain_r and gain_b update.
- busy  out  1  divider sequence in progress.
- stats_dropped  out  1  one-cycle pulse when a completed frame is discarded.
- pix_count  out  SUM_W  valid-pixel count of the last completed frame.

## Operation
- Reset values: gain_r, gain_g and gain_b = 256. gains_valid, busy and stats_dropped = 0. pix_count, accumulators and snapshots = 0. FSM in IDLE.
- csi_in_frame is registered once internally.
- Frame start is a rising edge (current 1, previous 0). On frame start the accumulators load the current pixel if rgb_valid is high, otherwise they load 0.
- During a frame (csi_in_frame = 1), each rgb_valid cycle adds R, G and B to sum_r, sum_g and sum_b, and increments cnt.
  - Every accumulator saturates at 2^SUM_W-1 and never wraps.
- rgb_valid while csi_in_frame = 0 is ignored.
- Frame end is a falling edge, sampled in cycle T. In cycle T:
  - cnt is copied to pix_count.
  - If cnt < MIN_PIX: nothing else happens and the gains are unchanged.
  - Else if the FSM is not IDLE: stats_dropped pulses at T+1 and the frame is discarded.
  - Else: the sums are copied to snapshot registers and the FSM leaves IDLE.
  - The accumulators are free to take the next frame immediately.
- FSM states:
  - IDLE -> DIV_R on an accepted frame end.
  - DIV_R, SUM_W+8 cycles: computes q_r = (snap_g << 8) / snap_r.
  - DIV_B, SUM_W+8 cycles: computes q_b = (snap_g << 8) / snap_b.
  - DONE, 1 cycle: updates the gain registers and pulses gains_valid. Returns to IDLE.
  - busy = (state != IDLE).
- Gain rules:
  - Divisor 0 gives gain 256 (unity).
  - Quotient > 2^GAIN_W-1 clamps to 2^GAIN_W-1 (1023).
  - Otherwise gain = quotient[GAIN_W-1:0].
- Reset asserted mid-division aborts the sequence. All outputs return to their reset values and no gains_valid pulse is produced.

## Timing
- Accumulator update latency: 1 cycle after the rgb_valid sample.
- Gain latency: gain_r, gain_b and gains_valid become visible exactly 2*(SUM_W+8)+2 cycles after cycle T. With defaults this is 82 cycles.
- Gain outputs change only on the gains_valid cycle and are otherwise stable.
- A frame start during DIV_R or DIV_B is legal. Division uses the snapshots and the new frame accumulates in parallel.
- Back-to-back frames shorter than 82 cycles of blanking plus active time are not supported for gain updates. Those frames raise stats_dropped.

## Structure
- top_pkg gains:
  - Constants AWB_GAIN_ONE = 256 and AWB_GAIN_MAX = 1023.
  - Enum awb_state_t {IDLE, DIV_R, DIV_B, DONE}.
- Sub-module isp_seq_divider: restoring divider with parameter W.
  - Ports: clk, rst, start, numer[W-1:0], denom[W-1:0], done, quot[W-1:0].
  - Processes one quotient bit per cycle and finishes in W cycles.
  - Instantiated once with W = SUM_W+8 and reused for R, then B.

## Test plan
- 640×2 frame, every pixel R=64, G=128, B=128 -> gain_r=512, gain_b=256, gain_g=256, pix_count=1280, gains_valid exactly 82 cycles after the falling edge.
- 2048-pixel frame with R=16, G=200, B=200 -> gain_r clamps to 1023, gain_b=256.
- 2048-pixel frame with R=0, G=100, B=50 -> gain_r=256 (zero divisor), gain_b=512.
- 500-pixel frame (< MIN_PIX), then rgb_valid pulses with csi_in_frame low -> no gains_valid, gains unchanged, pix_count=500, stray pixels not counted.
- Second qualifying frame ends 30 cycles after the first -> stats_dropped pulses once, and only the first frame's gains appear.
- Assert rst during DIV_B -> all outputs return to reset values next edge, no gains_valid, and the next full frame produces correct gains.
